// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : nn_pkg
//  Purpose : Shared sizes, widths, FSM state encoding and accumulator sizing
//            helper for the dense (fully connected) classifier layer.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package nn_pkg;

    // Layer geometry: 5x5x64 pooled features flattened into 10 class scores.
    localparam int c_IN_LEN    = 1600;
    localparam int c_OUT_LEN   = 10;

    // Element widths (all signed two's complement).
    localparam int c_IN_W      = 12;
    localparam int c_W_W       = 4;
    localparam int c_SCORE_W   = 16;

    // Minimum accumulator width; enough for 1600 products of 12x4 bits
    // plus a bias without internal overflow.
    localparam int c_ACC_W     = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Accumulator width for a given geometry: product width plus growth for
    // in_len additions plus one bit for the bias, never below c_ACC_W.
    function automatic int acc_width(input int in_w, input int w_w, input int in_len);
        int w;
        w = in_w + w_w + $clog2(in_len) + 1;
        return (w > c_ACC_W) ? w : c_ACC_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dense_classifier_mac_unit.sv
`default_nettype none
// ============================================================================
//  Module  : mac_unit
//  Purpose : Signed multiply-accumulate. 'sum' is the combinational value
//            acc + a*b; the accumulator takes 'sum' when en=1, or is loaded
//            with load_val (sign-extended bias) when load=1.
//  Ports   : clock, reset (sync, active-high), load, load_val, en, a, b, sum
//  Revision: 1.0 - initial release
// ============================================================================
module mac_unit
    import nn_pkg::*;
#(
    parameter int IN_W  = c_IN_W,
    parameter int W_W   = c_W_W,
    parameter int ACC_W = c_ACC_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic signed [ACC_W-1:0] load_val,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [W_W-1:0]   b,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [ACC_W-1:0]      r_acc;
    logic signed [IN_W+W_W-1:0]   w_prod;
    logic signed [ACC_W-1:0]      w_prod_ext;

    assign w_prod     = a * b;
    assign w_prod_ext = {{(ACC_W-IN_W-W_W){w_prod[IN_W+W_W-1]}}, w_prod};
    assign sum        = r_acc + w_prod_ext;

    // Load has priority over accumulate: the last product of a row is
    // consumed through 'sum' on the same edge the next bias is loaded.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc <= '0;
        end else if (load) begin
            r_acc <= load_val;
        end else if (en) begin
            r_acc <= sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dense_classifier.sv
`default_nettype none
// ============================================================================
//  Module  : dense_classifier
//  Purpose : Fully connected layer with argmax. On an accepted start edge the
//            inputs are latched and one product per cycle is accumulated;
//            OUT_LEN*IN_LEN cycles later scores/class_id are valid and done
//            is raised.
//  Ports   : clock, reset (sync, active-high), start (rising-edge request),
//            features[IN_LEN*IN_W], coef[OUT_LEN*IN_LEN*W_W],
//            bias[OUT_LEN*W_W]  ->  scores[OUT_LEN*SCORE_W],
//            class_id[$clog2(OUT_LEN)], busy, done
//  Config  : DENSE_SATURATE_EN defined   -> scores clamp to SCORE_W range
//            DENSE_SATURATE_EN undefined -> scores wrap (low SCORE_W bits)
//  Revision: 1.0 - initial release
// ============================================================================
module dense_classifier
    import nn_pkg::*;
#(
    parameter int IN_LEN  = c_IN_LEN,
    parameter int OUT_LEN = c_OUT_LEN,
    parameter int IN_W    = c_IN_W,
    parameter int W_W     = c_W_W,
    parameter int SCORE_W = c_SCORE_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [IN_LEN*IN_W-1:0]       features,
    input  logic [OUT_LEN*IN_LEN*W_W-1:0] coef,
    input  logic [OUT_LEN*W_W-1:0]       bias,
    output logic [OUT_LEN*SCORE_W-1:0]   scores,
    output logic [$clog2(OUT_LEN)-1:0]   class_id,
    output logic                         busy,
    output logic                         done
);

    localparam int c_ACC = acc_width(IN_W, W_W, IN_LEN);
    localparam int c_IW  = $clog2(IN_LEN);
    localparam int c_OW  = $clog2(OUT_LEN);

    // Registered state
    state_t                        r_state;
    logic                          r_start_d;
    logic [IN_LEN*IN_W-1:0]        r_feat;
    logic [OUT_LEN*IN_LEN*W_W-1:0] r_coef;
    logic [OUT_LEN*W_W-1:0]        r_bias;
    logic [c_IW-1:0]               r_i;
    logic [c_OW-1:0]               r_o;
    logic [OUT_LEN*SCORE_W-1:0]    r_scores;
    logic [c_OW-1:0]               r_class;
    logic signed [SCORE_W-1:0]     r_max;
    logic                          r_busy;
    logic                          r_done;

    // Combinational
    logic                          w_accept;
    logic                          w_last_i;
    logic                          w_last_o;
    logic [c_OW-1:0]               w_o_next;
    logic signed [IN_W-1:0]        w_a;
    logic signed [W_W-1:0]         w_b;
    logic signed [W_W-1:0]         w_bias_sel;
    logic signed [c_ACC-1:0]       w_load_val;
    logic                          w_load;
    logic                          w_en;
    logic signed [c_ACC-1:0]       w_sum;
    logic signed [SCORE_W-1:0]     w_score;

    // Only a fresh 0->1 transition starts a run, and never while one is active.
    assign w_accept = start & ~r_start_d & (r_state != MAC);

    assign w_last_i = (r_i == c_IW'(IN_LEN - 1));
    assign w_last_o = (r_o == c_OW'(OUT_LEN - 1));
    assign w_o_next = w_last_o ? '0 : (r_o + 1'b1);

    assign w_a = r_feat[int'(r_i) * IN_W +: IN_W];
    assign w_b = r_coef[(int'(r_o) * IN_LEN + int'(r_i)) * W_W +: W_W];

    // The accept edge loads bias[0] straight from the port because the
    // latched copy is only written on that same edge.
    assign w_bias_sel = w_accept ? bias[W_W-1:0] : r_bias[int'(w_o_next) * W_W +: W_W];
    assign w_load_val = {{(c_ACC-W_W){w_bias_sel[W_W-1]}}, w_bias_sel};
    assign w_load     = w_accept | ((r_state == MAC) & w_last_i);
    assign w_en       = (r_state == MAC);

    mac_unit #(
        .IN_W  (IN_W),
        .W_W   (W_W),
        .ACC_W (c_ACC)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_en),
        .a        (w_a),
        .b        (w_b),
        .sum      (w_sum)
    );

`ifdef DENSE_SATURATE_EN
    localparam logic signed [c_ACC-1:0] c_SMAX = {{(c_ACC-SCORE_W+1){1'b0}}, {(SCORE_W-1){1'b1}}};
    localparam logic signed [c_ACC-1:0] c_SMIN = {{(c_ACC-SCORE_W+1){1'b1}}, {(SCORE_W-1){1'b0}}};

    always_comb begin
        w_score = w_sum[SCORE_W-1:0];
        if (w_sum > c_SMAX) begin
            w_score = {1'b0, {(SCORE_W-1){1'b1}}};
        end else if (w_sum < c_SMIN) begin
            w_score = {1'b1, {(SCORE_W-1){1'b0}}};
        end
    end
`else
    // Two's-complement wrap: the upper accumulator bits are discarded.
    logic w_sum_unused;
    assign w_sum_unused = ^w_sum[c_ACC-1:SCORE_W];
    assign w_score      = w_sum[SCORE_W-1:0];
`endif

    // Input snapshot; not reset since it is always rewritten before use.
    always_ff @(posedge clock) begin
        if (!reset && w_accept) begin
            r_feat <= features;
            r_coef <= coef;
            r_bias <= bias;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_start_d <= 1'b0;
            r_i       <= '0;
            r_o       <= '0;
            r_scores  <= '0;
            r_class   <= '0;
            r_max     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_start_d <= start;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state <= MAC;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_i     <= '0;
                        r_o     <= '0;
                    end
                end
                MAC: begin
                    if (w_last_i) begin
                        r_scores[int'(r_o) * SCORE_W +: SCORE_W] <= w_score;
                        // Row 0 seeds the running maximum; strict '>' keeps
                        // the lowest index on ties.
                        if ((r_o == '0) || (w_score > r_max)) begin
                            r_max   <= w_score;
                            r_class <= r_o;
                        end
                        r_i <= '0;
                        r_o <= w_o_next;
                        if (w_last_o) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign scores   = r_scores;
    assign class_id = r_class;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dense_classifier.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dense_classifier
//  Purpose : Self-checking bench for dense_classifier. A small 4x3 instance
//            is driven with directed and random vectors and compared with an
//            arithmetic reference model; a default-size 1600x10 instance
//            runs one long directed case.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_dense_classifier;

    localparam int N  = 4;
    localparam int M  = 3;
    localparam int IW = 12;
    localparam int WW = 4;
    localparam int SW = 16;
    localparam int BN = 1600;
    localparam int BM = 10;

    logic               clock;
    logic               reset;
    logic               start;
    logic [N*IW-1:0]    features;
    logic [M*N*WW-1:0]  coef;
    logic [M*WW-1:0]    bias;
    logic [M*SW-1:0]    scores;
    logic [1:0]         class_id;
    logic               busy;
    logic               done;

    logic               big_start;
    logic [BN*IW-1:0]   big_features;
    logic [BM*BN*WW-1:0] big_coef;
    logic [BM*WW-1:0]   big_bias;
    logic [BM*SW-1:0]   big_scores;
    logic [3:0]         big_class_id;
    logic               big_busy;
    logic               big_done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference stimulus and expectations
    int     fa[N];
    int     wa[M][N];
    int     ba[M];
    longint es[M];
    int     ec;

    dense_classifier #(
        .IN_LEN  (N),
        .OUT_LEN (M),
        .IN_W    (IW),
        .W_W     (WW),
        .SCORE_W (SW)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .features (features),
        .coef     (coef),
        .bias     (bias),
        .scores   (scores),
        .class_id (class_id),
        .busy     (busy),
        .done     (done)
    );

    dense_classifier u_big (
        .clock    (clock),
        .reset    (reset),
        .start    (big_start),
        .features (big_features),
        .coef     (big_coef),
        .bias     (big_bias),
        .scores   (big_scores),
        .class_id (big_class_id),
        .busy     (big_busy),
        .done     (big_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint reduce(input longint s);
        longint t;
`ifdef DENSE_SATURATE_EN
        if (s > 32767) t = 32767;
        else if (s < -32768) t = -32768;
        else t = s;
`else
        t = s & 64'hFFFF;
        if (t >= 32768) t = t - 65536;
`endif
        return t;
    endfunction

    // Dot products in plain integer arithmetic, then reduce and argmax.
    task automatic model();
        longint s;
        ec = 0;
        for (int o = 0; o < M; o++) begin
            s = ba[o];
            for (int i = 0; i < N; i++) s += longint'(fa[i]) * wa[o][i];
            es[o] = reduce(s);
            if (o > 0 && es[o] > es[ec]) ec = o;
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) features[i*IW +: IW] = IW'(fa[i]);
        for (int o = 0; o < M; o++) begin
            bias[o*WW +: WW] = WW'(ba[o]);
            for (int i = 0; i < N; i++) coef[(o*N+i)*WW +: WW] = WW'(wa[o][i]);
        end
    endtask

    task automatic fill(input int f, input int w, input int b0, input int b1, input int b2);
        for (int i = 0; i < N; i++) fa[i] = f;
        for (int o = 0; o < M; o++)
            for (int i = 0; i < N; i++) wa[o][i] = w;
        ba[0] = b0; ba[1] = b1; ba[2] = b2;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) fa[i] = int'($urandom_range(4095)) - 2048;
        for (int o = 0; o < M; o++) begin
            ba[o] = int'($urandom_range(15)) - 8;
            for (int i = 0; i < N; i++) wa[o][i] = int'($urandom_range(15)) - 8;
        end
    endtask

    function automatic longint got(input int o);
        logic signed [SW-1:0] v;
        v = scores[o*SW +: SW];
        return longint'(v);
    endfunction

    // One run: accept, scramble the buses, wait for done with a bound,
    // compare timing and results; start held 'hold' extra cycles after done.
    task automatic run(input string tag, input int hold);
        int cnt;
        model();
        pack();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        chk({tag, "/busy_on_accept"}, longint'(busy), 1);
        chk({tag, "/done_low_on_accept"}, longint'(done), 0);
        features = {$urandom(), $urandom()} >> 16;
        coef     = {$urandom(), $urandom()} >> 16;
        bias     = 12'($urandom());
        cnt = 0;
        while (!done && cnt < N*M + 10) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        chk({tag, "/cycles"}, cnt, N*M);
        chk({tag, "/busy_after"}, longint'(busy), 0);
        for (int o = 0; o < M; o++) chk($sformatf("%s/score%0d", tag, o), got(o), es[o]);
        chk({tag, "/class_id"}, longint'(class_id), ec);
        for (int k = 0; k < hold; k++) begin
            @(posedge clock);
            #1;
            chk({tag, "/hold_busy"}, longint'(busy), 0);
            chk({tag, "/hold_done"}, longint'(done), 1);
        end
        chk({tag, "/hold_class_id"}, longint'(class_id), ec);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        start = 1'b0;
        big_start = 1'b0;
        features = '0;
        coef = '0;
        bias = '0;
        big_features = '0;
        big_coef = '0;
        big_bias = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst/scores", longint'(scores), 0);
        chk("rst/class_id", longint'(class_id), 0);
        chk("rst/busy", longint'(busy), 0);
        chk("rst/done", longint'(done), 0);
        @(negedge clock);
        reset = 1'b0;

        fill(1, 1, 0, 0, 0);
        run("ones", 0);

        fill(2047, -8, -8, -8, -8);
        run("extreme", 0);

        fill(int'($urandom_range(100)), 0, 0, 7, -1);
        run("bias_only", 0);

        // Abort on the 5th MAC cycle.
        fill(1, 1, 3, 2, 1);
        pack();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("abort/scores", longint'(scores), 0);
        chk("abort/class_id", longint'(class_id), 0);
        chk("abort/busy", longint'(busy), 0);
        chk("abort/done", longint'(done), 0);
        @(negedge clock);
        reset = 1'b0;
        fill_rand();
        run("after_abort", 0);

        // Start held high for 40 cycles in total, then a fresh edge.
        fill_rand();
        run("held", 40 - 1 - N*M);
        fill_rand();
        run("second", 0);

        for (int t = 0; t < 15; t++) begin
            fill_rand();
            run($sformatf("rand%0d", t), 0);
        end

        // Default geometry: only class 9 has non-zero weights.
        for (int i = 0; i < BN; i++) begin
            big_features[i*IW +: IW] = 12'd1;
            big_coef[(9*BN+i)*WW +: WW] = 4'd1;
        end
        @(negedge clock);
        big_start = 1'b1;
        @(posedge clock);
        #1;
        chk("big/busy_on_accept", longint'(big_busy), 1);
        cnt = 0;
        while (!big_done && cnt < BN*BM + 20) begin
            @(posedge clock);
            #1;
            cnt++;
        end
        chk("big/cycles", cnt, BN*BM);
        for (int o = 0; o < BM; o++) begin
            logic signed [SW-1:0] v;
            v = big_scores[o*SW +: SW];
            chk($sformatf("big/score%0d", o), longint'(v), (o == 9) ? 1600 : 0);
        end
        chk("big/class_id", longint'(big_class_id), 9);
        @(negedge clock);
        big_start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dense_classifier.md
DENSE_CLASSIFIER -- requirements
Module: dense_classifier

Interface
REQ-001 Parameter IN_LEN, default 1600, flattened feature count (5x5x64 from the pooled conv stage).
REQ-002 Parameter OUT_LEN, default 10, number of class scores.
REQ-003 Parameter IN_W, default 12, feature element width, signed.
REQ-004 Parameter W_W, default 4, weight and bias width, signed.
REQ-005 Parameter SCORE_W, default 16, output score width, signed.
REQ-006 The port list SHALL be, clock and reset first:
- clock, input, 1, the only clock; all logic is on its rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, run request; the block acts on its rising edge.
- features, input, IN_LEN*IN_W, element i at [i*IN_W +: IN_W].
- coef, input, OUT_LEN*IN_LEN*W_W, weight (o,i) at [(o*IN_LEN+i)*W_W +: W_W].
- bias, input, OUT_LEN*W_W, bias o at [o*W_W +: W_W].
- scores, output, OUT_LEN*SCORE_W, score o at [o*SCORE_W +: SCORE_W].
- class_id, output, $clog2(OUT_LEN), index of the maximum score.
- busy, output, 1, high while computing.
- done, output, 1, high when results are valid.

Function
REQ-007 FSM states SHALL be IDLE, MAC and DONE, and the block SHALL leave reset in IDLE.
REQ-008 A start rising edge (start=1 with previous start=0) seen in IDLE or DONE SHALL be accepted. On that edge the block SHALL:
- latch features, coef and bias internally;
- clear done, set busy;
- set o=0, i=0, acc=sign-extended bias[0];
- enter MAC.
REQ-009 A start that stays high, and any start edge seen in MAC, SHALL be ignored.
REQ-010 Each MAC cycle SHALL add one signed product features[i]*coef(o,i) to a signed accumulator of at least 28 bits, then increment i.
REQ-011 On the cycle where i=IN_LEN-1, the block SHALL:
- write acc+product, reduced to SCORE_W per REQ-019, into scores[o];
- update argmax;
- reload acc with bias[o+1];
- set i=0 and increment o.
REQ-012 Argmax SHALL use strict greater-than, so a tie keeps the lower index; score 0 always initialises the running maximum.
REQ-013 The edge that completes the last product SHALL enter DONE with done=1, busy=0, and scores and class_id final. This gives exactly OUT_LEN*IN_LEN cycles from the accept edge to done high.
REQ-014 scores and class_id SHALL hold stable in DONE until the next accepted start.
REQ-015 Changes on the input buses after the accept edge SHALL NOT affect the current run.

Reset
REQ-016 When reset=1 at a clock edge, the block SHALL:
- enter IDLE;
- set scores=0, class_id=0, busy=0, done=0;
- clear all counters and the accumulator;
- clear the start history register.
REQ-017 Reset SHALL abort a run in progress with no partial results kept, and SHALL take priority over a start on the same edge.

Configuration
REQ-018 Macro DENSE_SATURATE_EN SHALL select how a score is reduced to SCORE_W bits.
REQ-019 With DENSE_SATURATE_EN defined, a score above 2^(SCORE_W-1)-1 or below -2^(SCORE_W-1) SHALL clamp to that bound. Without it, the score SHALL be truncated to its low SCORE_W bits (two's-complement wrap).

Structure
REQ-020 Package nn_pkg SHALL hold the default widths, the sizes IN_LEN and OUT_LEN, the FSM state enum, and the accumulator width constant.
REQ-021 One sub-module, mac_unit, SHALL implement the signed multiply-accumulate with a synchronous clear-to-bias load.

Verification (IN_LEN=4, OUT_LEN=3 unless stated)
REQ-022 All features=1, all weights=1, all biases=0; pulse start -> scores=4,4,4, class_id=0 (tie), done rises exactly 12 cycles after the accept edge.
REQ-023 Features=2047, weights=-8, biases=-8 -> score=-65512 per class:
- with DENSE_SATURATE_EN, every score=16'h8000;
- without it, every score=16'h0018.
REQ-024 Weights=0, biases=0,7,-1 -> scores=0,7,-1 and class_id=1.
REQ-025 Reset asserted on the 5th MAC cycle -> next cycle shows IDLE with scores=0, class_id=0, done=0, busy=0; a following start completes correctly.
REQ-026 Start held high for 40 cycles -> exactly one run; after busy drops, start low then high -> a second run, with done low during it.
REQ-027 Defaults (1600x10): features=1, weight(o,i)=1 only for o=9, biases=0 -> scores[9]=1600, others 0, class_id=9, done after 16000 cycles.
